// File: rtl/bus_cycle_sequencer_if.sv
// 8085 machine-cycle bus bundle: requester handshake on one side, bus pins on the other.
// The slave modport is the sequencer; the master modport is the core/pin side.
interface bus_cycle_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cycle_req;
  logic [2:0]        cycle_type;
  logic [ADDR_W-1:0] cycle_addr;
  logic [DATA_W-1:0] cycle_wdata;
  logic              ready;
  logic              cycle_ack;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              cycle_done;
  logic              dbus_to_instr_reg;
  logic [DATA_W-1:0] ad_in;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic [7:0]        haddress;
  logic              ALE, RDn, WRn, IOMn, S0, S1;
  logic [2:0]        tstate;

  modport slave (
    input  cycle_req, cycle_type, cycle_addr, cycle_wdata, ready, ad_in,
    output cycle_ack, rdata, rdata_valid, cycle_done, dbus_to_instr_reg,
           ad_out, ad_oe, haddress, ALE, RDn, WRn, IOMn, S0, S1, tstate
  );

  modport master (
    output cycle_req, cycle_type, cycle_addr, cycle_wdata, ready, ad_in,
    input  cycle_ack, rdata, rdata_valid, cycle_done, dbus_to_instr_reg,
           ad_out, ad_oe, haddress, ALE, RDn, WRn, IOMn, S0, S1, tstate
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// 8085 machine-cycle sequencer (T1/T2/TW/T3/T4) driving ALE, RDn/WRn, status and the muxed AD bus.
// Optional READY_WAIT_EN: when defined, READY inserts TW states; otherwise T2 always advances to T3.
module bus_cycle_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  bus_cycle_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  localparam logic [2:0] C_FETCH = 3'd0;
  localparam logic [2:0] C_MRD   = 3'd1;
  localparam logic [2:0] C_MWR   = 3'd2;
  localparam logic [2:0] C_IORD  = 3'd3;
  localparam logic [2:0] C_IOWR  = 3'd4;
  localparam logic [2:0] C_INTA  = 3'd5;

  logic [2:0]        r_state, w_next;
  logic [2:0]        r_type;
  logic [DATA_W-1:0] r_wdata, r_ad_out, r_rdata;
  logic [7:0]        r_haddr;
  logic              r_iomn, r_rdata_valid;

  logic w_is_write, w_is_read, w_has_t4, w_final, w_req_ok, w_accept;
  logic w_strobe, w_ready, w_s1, w_s0;

`ifdef READY_WAIT_EN
  assign w_ready = bus.ready;
`else
  logic w_unused_ready;
  assign w_unused_ready = bus.ready;
  assign w_ready        = 1'b1;
`endif

  assign w_is_write = (r_type == C_MWR) || (r_type == C_IOWR);
  assign w_is_read  = !w_is_write;
  assign w_has_t4   = (r_type == C_FETCH) || (r_type == C_INTA);
  assign w_final    = ((r_state == S_T3) && !w_has_t4) || (r_state == S_T4);
  assign w_req_ok   = bus.cycle_req && (bus.cycle_type <= C_INTA);
  // Accept in IDLE or in the last T-state so back-to-back cycles have no idle gap.
  assign w_accept   = w_req_ok && ((r_state == S_IDLE) || w_final);
  assign w_strobe   = (r_state == S_T2) || (r_state == S_TW) || (r_state == S_T3);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = w_ready ? S_T3 : S_TW;
      S_TW:    if (w_ready) w_next = S_T3;
      S_T3:    if (w_has_t4) w_next = S_T4;
               else          w_next = w_accept ? S_T1 : S_IDLE;
      S_T4:    w_next = w_accept ? S_T1 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_type        <= C_FETCH;
      r_wdata       <= '0;
      r_ad_out      <= '0;
      r_haddr       <= '0;
      r_iomn        <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_rdata_valid <= (r_state == S_T3) && w_is_read;
      if ((r_state == S_T3) && w_is_read)
        r_rdata <= bus.ad_in;
      if (w_accept) begin
        r_type   <= bus.cycle_type;
        r_wdata  <= bus.cycle_wdata;
        r_haddr  <= bus.cycle_addr[ADDR_W-1 -: 8];
        r_ad_out <= bus.cycle_addr[DATA_W-1:0];
        r_iomn   <= (bus.cycle_type == C_IORD) || (bus.cycle_type == C_IOWR) ||
                    (bus.cycle_type == C_INTA);
      end else if ((r_state == S_T1) && w_is_write) begin
        r_ad_out <= r_wdata;
      end
    end
  end

  always_comb begin
    w_s1 = 1'b0;
    w_s0 = 1'b0;
    if (r_state != S_IDLE) begin
      case (r_type)
        C_FETCH: {w_s1, w_s0} = 2'b11;
        C_MRD:   {w_s1, w_s0} = 2'b10;
        C_MWR:   {w_s1, w_s0} = 2'b01;
        C_IORD:  {w_s1, w_s0} = 2'b10;
        C_IOWR:  {w_s1, w_s0} = 2'b01;
        C_INTA:  {w_s1, w_s0} = 2'b11;
        default: {w_s1, w_s0} = 2'b00;
      endcase
    end
  end

  // Read and write strobes decode from disjoint type sets, so RDn and WRn never both go low.
  assign bus.ALE               = (r_state == S_T1);
  assign bus.RDn               = !(w_strobe && w_is_read);
  assign bus.WRn               = !(w_strobe && w_is_write);
  assign bus.ad_oe             = (r_state == S_T1) || (w_strobe && w_is_write);
  assign bus.IOMn              = r_iomn;
  assign bus.S1                = w_s1;
  assign bus.S0                = w_s0;
  assign bus.ad_out            = r_ad_out;
  assign bus.haddress          = r_haddr;
  assign bus.cycle_ack         = (r_state == S_T1);
  assign bus.cycle_done        = w_final;
  assign bus.dbus_to_instr_reg = (r_state == S_T3) && w_has_t4;
  assign bus.rdata             = r_rdata;
  assign bus.rdata_valid       = r_rdata_valid;
  assign bus.tstate            = r_state;
endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
- Machine-cycle controller for the 8085 external bus.
- Sequences T1/T2/TW/T3/T4 states for one requested machine cycle at a time.
- Drives ALE, RDn, WRn, IOMn, S1/S0, the multiplexed AD bus and high address byte.
- Generates the instruction-register load strobe during opcode fetch.
- Sits between the core control unit (requester) and the pins that the system testbench currently toggles by hand.

Parameters:
- ADDR_W, 16, external address width; high byte goes to haddress, low byte is muxed on AD.
- DATA_W, 8, data width of AD bus, wdata and rdata.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous active-low reset
- cycle_req  input  1  request a machine cycle; held until cycle_ack
- cycle_type  input  3  0=opcode fetch, 1=mem read, 2=mem write, 3=io read, 4=io write, 5=int ack; 6/7 reserved
- cycle_addr  input  ADDR_W  cycle address
- cycle_wdata  input  DATA_W  write data
- ready  input  1  external READY
- cycle_ack  output  1  one-cycle pulse in T1; inputs latched
- rdata  output  DATA_W  read data, registered
- rdata_valid  output  1  one-cycle pulse after read data is captured
- cycle_done  output  1  high during the final T-state of a cycle
- dbus_to_instr_reg  output  1  IR load strobe
- ad_in  input  DATA_W  AD bus sampled value
- ad_out  output  DATA_W  AD bus drive value
- ad_oe  output  1  AD output enable
- haddress  output  8  A15..A8
- ALE, RDn, WRn, IOMn, S0, S1  output  1 each  8085 bus pins
- tstate  output  3  0=IDLE, 1=T1, 2=T2, 3=TW, 4=T3, 5=T4

Behaviour:
- Reset (rst=0, async):
  - State IDLE; ALE=0, RDn=1, WRn=1, IOMn=0, S1=S0=0, ad_oe=0.
  - ad_out=0, haddress=0, rdata=0; all pulses 0.
  - Reset asserted mid-cycle aborts the cycle immediately; no done or valid is issued.
- Accept point:
  - cycle_req sampled at rising edge while in IDLE, or in the final T-state (back-to-back, no idle cycle).
  - Type, address and wdata are latched at that edge; the next state is T1.
  - Reserved type: request ignored, no ack, stays IDLE.
- Status per type (IOMn,S1,S0), held from T1 through the final state:
  - fetch 0,1,1
  - mem read 0,1,0
  - mem write 0,0,1
  - io read 1,1,0
  - io write 1,0,1
  - int ack 1,1,1
  - In IDLE: S1=S0=0, IOMn holds its last value.
- T1:
  - ALE=1, ad_oe=1.
  - ad_out=addr[7:0]; haddress=addr[15:8] (held until the cycle ends).
  - cycle_ack=1.
- T2:
  - ALE=0.
  - Reads (fetch, mem/io read, int ack): ad_oe=0, RDn=0.
  - Writes: ad_out=wdata, ad_oe=1, WRn=0.
  - ready sampled at the end of T2: 1 → T3, 0 → TW.
- TW:
  - Strobes held.
  - Repeats while ready=0 at each edge; ready=1 → T3.
  - No cycle limit.
- T3:
  - Read strobe or write strobe still active.
  - Reads: at the edge leaving T3, rdata<=ad_in; RDn returns to 1; rdata_valid=1 for the following cycle.
  - Writes: WRn returns to 1 at the edge leaving T3.
  - Fetch and int ack: dbus_to_instr_reg=1 throughout T3.
  - Cycles without T4 assert cycle_done during T3.
- T4 (fetch and int ack only):
  - RDn=1, ad_oe=0; cycle_done=1.
  - Next state is T1 (if req pending) else IDLE.
- Pin invariant: RDn and WRn are never both 0.
- Latency: cycle_ack appears 1 clock after req is accepted. A 3-state cycle with ready=1 completes in 3 clocks; fetch completes in 4.

Optional Feature:
- Macro: READY_WAIT_EN.
- Defined: READY is honoured as above, with TW states inserted.
- Undefined: ready is ignored, TW is never entered and T2 always advances to T3; tstate code 3 never appears.

Test Plan:
- Reset, then opcode fetch at addr 0x1234 with ad_in=0x43 and ready=1:
  - T1: ALE=1, ad_out=0x34, haddress=0x12, IOMn/S1/S0=0/1/1.
  - RDn=0 in T2–T3; dbus_to_instr_reg=1 in T3.
  - rdata=0x43 with rdata_valid pulse in T4; cycle_done in T4; then IDLE.
- Mem write 0x00A5, wdata 0x5A:
  - Status 0/0/1; ad_out=0x5A with ad_oe=1 and WRn=0 in T2–T3.
  - RDn stays 1; cycle_done in T3; 3 clocks total.
- IO read 0x0020 with ready held low for 2 edges (READY_WAIT_EN):
  - Exactly 2 TW states; RDn stays 0 throughout; rdata captured only after T3.
- Back-to-back: fetch immediately followed by mem read with req held:
  - T4 is followed directly by T1 of the read; cycle_ack pulses twice.
- rst driven low during TW of a read:
  - Outputs return to reset values asynchronously (RDn=1, ad_oe=0); no rdata_valid.
- Reserved type 7 requested → no cycle_ack; tstate stays 0 for 5 clocks.
